// File: rtl/ram_stream_if.sv
// Command/response bundle for ram_stream: command strobe and fields in,
// registered read data, pointer and status out.
interface ram_stream_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 6
);
    // cmd_valid is a one-cycle strobe taken whenever busy is low; busy is the
    // only backpressure, and rvalid answers an accepted read exactly one cycle later.
    logic                 cmd_valid;
    logic                 cmd_write;
    logic                 cmd_stream;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [DATA_BITS-1:0] cmd_wdata;
    logic                 ptr_load;
    logic [ADDR_BITS-1:0] ptr_load_val;
    logic                 clear;
    logic [DATA_BITS-1:0] rdata;
    logic                 rvalid;
    logic [ADDR_BITS-1:0] ptr;
    logic                 busy;
    logic                 err;

    modport master (
        output cmd_valid, cmd_write, cmd_stream, cmd_addr, cmd_wdata,
        output ptr_load, ptr_load_val, clear,
        input  rdata, rvalid, ptr, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_stream, cmd_addr, cmd_wdata,
        input  ptr_load, ptr_load_val, clear,
        output rdata, rvalid, ptr, busy, err
    );
endinterface

// File: rtl/ram_stream.sv
// Single-port RAM with registered read, stream pointer and sticky range error.
// Define RAM_STREAM_CLEAR_EN to build the hardware clear sequencer.
module ram_stream #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 48,
    parameter int ADDR_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    ram_stream_if.slave  bus
);
    localparam logic [ADDR_BITS:0]   DEPTH_W = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST    = ADDR_BITS'(DEPTH - 1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                 err_q, err_d;

    logic                 busy;
    logic                 accept;
    logic                 in_range;
    logic [ADDR_BITS-1:0] eff_addr;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;

`ifdef RAM_STREAM_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_e;
    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        accept   = bus.cmd_valid && !busy;
        eff_addr = bus.cmd_stream ? ptr_q : bus.cmd_addr;
        in_range = {1'b0, eff_addr} < DEPTH_W;

        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ptr_d    = ptr_q;
        err_d    = err_q;

        wr_en    = accept && bus.cmd_write && in_range;
        wr_addr  = eff_addr;
        wr_data  = bus.cmd_wdata;
`ifdef RAM_STREAM_CLEAR_EN
        // The sequencer owns the write port while clearing; commands are locked out.
        if (busy) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
        end
`endif

        if (accept) begin
            if (!bus.cmd_write) begin
                rvalid_d = 1'b1;
                rdata_d  = in_range ? mem_q[eff_addr] : '0;
            end
            if (!in_range) err_d = 1'b1;
            if (bus.cmd_stream) ptr_d = (ptr_q == LAST || !in_range) ? '0 : ptr_q + 1'b1;
        end
        // A load overrides any increment from a stream command in the same cycle.
        if (bus.ptr_load) ptr_d = bus.ptr_load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage is never reset; reset only suppresses the write in its own cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.ptr    = ptr_q;
    assign bus.busy   = busy;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_ram_stream.sv
// Directed bench for ram_stream with a word-level model and per-cycle compare.
// Clear-sequencer tests follow RAM_STREAM_CLEAR_EN.
module tb_ram_stream;
    localparam int DW = 8;
    localparam int D  = 48;
    localparam int AW = 6;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_stream_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();
    ram_stream #(.DATA_BITS(DW), .DEPTH(D), .ADDR_BITS(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // model state: word array with a known flag per word
    logic [DW-1:0] mm [D];
    bit            mk [D];
    logic [DW-1:0] e_rdata    = '0;
    bit            e_rd_known = 1'b1;
    bit            e_rvalid   = 1'b0;
    int            e_ptr      = 0;
    bit            e_err      = 1'b0;
    int            busy_left  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        int a;
        bit bsy;
        if (rst) begin
            e_rdata = '0; e_rd_known = 1'b1; e_rvalid = 1'b0;
            e_ptr = 0; e_err = 1'b0; busy_left = 0;
        end else begin
            bsy = busy_left > 0;
            e_rvalid = 1'b0;
            if (bsy) begin
                mm[D - busy_left] = '0;
                mk[D - busy_left] = 1'b1;
                busy_left--;
            end
            if (bus.cmd_valid && !bsy) begin
                a = bus.cmd_stream ? e_ptr : int'(bus.cmd_addr);
                if (a >= D) e_err = 1'b1;
                if (bus.cmd_write) begin
                    if (a < D) begin mm[a] = bus.cmd_wdata; mk[a] = 1'b1; end
                end else begin
                    e_rvalid = 1'b1;
                    if (a < D) begin e_rdata = mm[a]; e_rd_known = mk[a]; end
                    else begin e_rdata = '0; e_rd_known = 1'b1; end
                end
                if (bus.cmd_stream) e_ptr = (a + 1 >= D) ? 0 : a + 1;
            end
            if (bus.ptr_load) e_ptr = int'(bus.ptr_load_val);
`ifdef RAM_STREAM_CLEAR_EN
            if (!bsy && bus.clear) busy_left = D;
`endif
        end
    endtask

    // scoreboard compare: every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            check("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
            check("ptr",    32'(bus.ptr),    32'(e_ptr));
            check("err",    32'(bus.err),    32'(e_err));
            check("busy",   32'(bus.busy),   32'(busy_left > 0));
            if (e_rd_known) check("rdata", 32'(bus.rdata), 32'(e_rdata));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_stream = 1'b0;
        bus.ptr_load = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_stream = 1'b0;
        bus.cmd_addr = AW'(a); bus.cmd_wdata = DW'(d);
        tick();
    endtask

    task automatic rd(input int a);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_stream = 1'b0;
        bus.cmd_addr = AW'(a);
        tick();
    endtask

    task automatic swr(input int d);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_stream = 1'b1;
        bus.cmd_wdata = DW'(d);
        tick();
    endtask

    task automatic srd();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_stream = 1'b1;
        tick();
    endtask

    task automatic load(input int v);
        bus.ptr_load = 1'b1; bus.ptr_load_val = AW'(v);
        tick();
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < D; i++) wr(i, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_stream = 1'b0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.ptr_load = 1'b0;
        bus.ptr_load_val = '0; bus.clear = 1'b0;
        @(negedge clk);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_rdata",  32'(bus.rdata),  32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_ptr",    32'(bus.ptr),    32'h0);
        check("rst_err",    32'(bus.err),    32'h0);
        check("rst_busy",   32'(bus.busy),   32'h0);

        // random access, write then immediate read
        wr(3, 8'hA5);
        rd(3);
        check("ra_rdata",  32'(bus.rdata),  32'hA5);
        check("ra_rvalid", 32'(bus.rvalid), 32'h1);
        tick();
        check("ra_rvalid_drop", 32'(bus.rvalid), 32'h0);
        check("ra_rdata_hold",  32'(bus.rdata),  32'hA5);
        check("ra_ptr", 32'(bus.ptr), 32'h0);

        // stream wrap across DEPTH-1
        load(46);
        swr(8'h11); swr(8'h22); swr(8'h33);
        check("wrap_ptr", 32'(bus.ptr), 32'd1);
        load(46);
        srd(); check("wrap_rd0", 32'(bus.rdata), 32'h11);
        srd(); check("wrap_rd1", 32'(bus.rdata), 32'h22);
        srd(); check("wrap_rd2", 32'(bus.rdata), 32'h33);
        rd(0); check("wrap_word0", 32'(bus.rdata), 32'h33);

        // load and stream read in one cycle
        wr(5, 8'h5A);
        load(5);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_stream = 1'b1;
        bus.ptr_load = 1'b1; bus.ptr_load_val = AW'(9);
        tick();
        check("ld_rdata", 32'(bus.rdata), 32'h5A);
        check("ld_ptr",   32'(bus.ptr),   32'd9);

        // out of range
        wr(2, 8'h02);
        check("oor_err_pre", 32'(bus.err), 32'h0);
        wr(50, 8'h77);
        check("oor_err", 32'(bus.err), 32'h1);
        rd(2);  check("oor_alias", 32'(bus.rdata), 32'h02);
        rd(63);
        check("oor_rdata",  32'(bus.rdata),  32'h0);
        check("oor_rvalid", 32'(bus.rvalid), 32'h1);
        load(60);
        swr(8'h99);
        check("oor_ptr_wrap", 32'(bus.ptr), 32'h0);
        check("oor_err_sticky", 32'(bus.err), 32'h1);

        fill(8'hFF);
`ifdef RAM_STREAM_CLEAR_EN
        // clear with a concurrent write, read and load mid-clear
        bus.clear = 1'b1;
        wr(7, 8'h3C);
        check("clr_busy_rise", 32'(bus.busy), 32'h1);
        n = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            n++;
            if (i == 5) begin
                rd(4);
                check("clr_mid_rvalid", 32'(bus.rvalid), 32'h0);
            end else if (i == 8) begin
                load(20);
                check("clr_mid_load", 32'(bus.ptr), 32'd20);
            end else begin
                tick();
            end
        end
        check("clr_busy_len", 32'(n), 32'd48);
        check("clr_err_kept", 32'(bus.err), 32'h1);
        for (int i = 0; i < D; i++) rd(i);
        check("clr_word47", 32'(bus.rdata), 32'h0);

        // reset at clear cycle 10
        fill(8'hFF);
        bus.clear = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmc_busy", 32'(bus.busy), 32'h0);
        check("rmc_err",  32'(bus.err),  32'h0);
        rd(9);  check("rmc_word9",  32'(bus.rdata), 32'h00);
        rd(10); check("rmc_word10", 32'(bus.rdata), 32'hFF);
        for (int i = 0; i < D; i++) rd(i);
`else
        // clear is inert without the sequencer
        bus.clear = 1'b1;
        tick();
        check("noclr_busy", 32'(bus.busy), 32'h0);
        tick();
        rd(0); check("noclr_word0", 32'(bus.rdata), 32'hFF);
        wr(1, 8'h42);
        rd(1); check("noclr_word1", 32'(bus.rdata), 32'h42);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
